// File: rtl/cbm2_video_timing.sv
// rtl/cbm2_video_timing.sv - CRTC-style raster timing generator for the CBM-II video path
//
// Purpose: divides clk down to a pixel enable and walks a raster of H_TOTAL pixels by
// V_TOTAL lines. V_TOTAL is NTSC_TOTAL or PAL_TOTAL, chosen by the latched mode. The
// block emits blank/sync strobes, raster counters and character-cell addresses for the
// fetch logic.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   pal          in   0=NTSC, 1=PAL; captured on the first pixel of every frame
//   ce_pix       out  one clk high per CLK_DIV clks, registered
//   hcount       out  [9:0] pixel position within the line
//   vcount       out  [8:0] line position within the frame
//   HBlank       out  hcount >= H_ACTIVE
//   HSync        out  H_SS <= hcount < H_SE
//   VBlank       out  vcount >= V_ACTIVE
//   VSync        out  VSS <= vcount < VSE of the latched mode
//   ma           out  [10:0] character cell address (row*COLS + col)
//   ra           out  [2:0] raster line within the character row
//   char_fetch   out  1-clk strobe: ma/ra address the next 8-pixel cell
//   frame_start  out  1-clk strobe on the pixel that lands on h=v=0
module cbm2_video_timing #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_SS       = 656,
  parameter int H_SE       = 720,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 200,
  parameter int COLS       = 80,
  parameter int NTSC_TOTAL = 262,
  parameter int NTSC_VSS   = 230,
  parameter int NTSC_VSE   = 233,
  parameter int PAL_TOTAL  = 312,
  parameter int PAL_VSS    = 256,
  parameter int PAL_VSE    = 259
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pal,
  output logic        ce_pix,
  output logic [9:0]  hcount,
  output logic [8:0]  vcount,
  output logic        HBlank,
  output logic        HSync,
  output logic        VBlank,
  output logic        VSync,
  output logic [10:0] ma,
  output logic [2:0]  ra,
  output logic        char_fetch,
  output logic        frame_start
);

  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]  H_SYNC_S  = 10'(H_SS);
  localparam logic [9:0]  H_SYNC_E  = 10'(H_SE);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [8:0]  V_ACT     = 9'(V_ACTIVE);
  localparam logic [8:0]  NTSC_LAST = 9'(NTSC_TOTAL - 1);
  localparam logic [8:0]  NTSC_VS_S = 9'(NTSC_VSS);
  localparam logic [8:0]  NTSC_VS_E = 9'(NTSC_VSE);
  localparam logic [8:0]  PAL_LAST  = 9'(PAL_TOTAL - 1);
  localparam logic [8:0]  PAL_VS_S  = 9'(PAL_VSS);
  localparam logic [8:0]  PAL_VS_E  = 9'(PAL_VSE);
  localparam logic [10:0] COLS_W    = 11'(COLS);

  logic [DIV_W-1:0] div_q, div_d;
  logic             run_q;
  logic             pal_r_q, pal_d;
  logic             ce_pix_q;
  logic [9:0]       hcount_q, h_d;
  logic [8:0]       vcount_q, v_d;
  logic             hblank_q, hblank_d;
  logic             hsync_q, hsync_d;
  logic             vblank_q, vblank_d;
  logic             vsync_q, vsync_d;
  logic [10:0]      ma_q, ma_d;
  logic [10:0]      row_base_q, row_base_d;
  logic [2:0]       ra_q, ra_d;
  logic             char_fetch_q;
  logic             frame_start_q;

  logic             tick;
  logic             line_wrap;
  logic             frame_wrap;
  logic             active_d;
  logic             fetch_d;
  logic [8:0]       v_last;

  always_comb begin
    tick       = (div_q == DIV_LAST);
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    v_last     = pal_r_q ? PAL_LAST : NTSC_LAST;
    line_wrap  = 1'b0;
    h_d        = hcount_q + 10'd1;
    v_d        = vcount_q;

    // The first pixel after reset lands on h=v=0 rather than advancing from the
    // all-zero reset state, so it behaves as a line and frame wrap.
    if (!run_q) begin
      h_d       = '0;
      v_d       = '0;
      line_wrap = 1'b1;
    end else if (hcount_q == H_LAST) begin
      h_d       = '0;
      line_wrap = 1'b1;
      v_d       = (vcount_q == v_last) ? '0 : vcount_q + 9'd1;
    end

    frame_wrap = line_wrap && (v_d == '0);
    // Mode is only taken at a frame boundary, so a frame never changes length midway.
    pal_d      = frame_wrap ? pal : pal_r_q;

    hblank_d   = (h_d >= H_ACT);
    hsync_d    = (h_d >= H_SYNC_S) && (h_d < H_SYNC_E);
    vblank_d   = (v_d >= V_ACT);
    vsync_d    = pal_d ? ((v_d >= PAL_VS_S) && (v_d < PAL_VS_E))
                       : ((v_d >= NTSC_VS_S) && (v_d < NTSC_VS_E));

    active_d   = (h_d < H_ACT) && (v_d < V_ACT);
    fetch_d    = active_d && (h_d[2:0] == 3'd0);

    // row_base steps by one character row when a new active line starts a new
    // 8-line row (the previous line had ra==7).
    row_base_d = row_base_q;
    if (frame_wrap) begin
      row_base_d = '0;
    end else if (line_wrap && (v_d[2:0] == 3'd0) && (v_d < V_ACT)) begin
      row_base_d = row_base_q + COLS_W;
    end

    // Outside the active area ma/ra hold their last cell.
    ma_d = ma_q;
    ra_d = ra_q;
    if (active_d) begin
      ra_d = v_d[2:0];
      if (h_d == '0) begin
        ma_d = row_base_d;
      end else if (h_d[2:0] == 3'd0) begin
        ma_d = ma_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      run_q         <= 1'b0;
      pal_r_q       <= 1'b0;
      ce_pix_q      <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hblank_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vblank_q      <= 1'b0;
      vsync_q       <= 1'b0;
      ma_q          <= '0;
      row_base_q    <= '0;
      ra_q          <= '0;
      char_fetch_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      ce_pix_q      <= tick;
      char_fetch_q  <= tick && fetch_d;
      frame_start_q <= tick && frame_wrap;
      if (tick) begin
        run_q      <= 1'b1;
        pal_r_q    <= pal_d;
        hcount_q   <= h_d;
        vcount_q   <= v_d;
        hblank_q   <= hblank_d;
        hsync_q    <= hsync_d;
        vblank_q   <= vblank_d;
        vsync_q    <= vsync_d;
        row_base_q <= row_base_d;
        ma_q       <= ma_d;
        ra_q       <= ra_d;
      end
    end
  end

  assign ce_pix      = ce_pix_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign HBlank      = hblank_q;
  assign HSync       = hsync_q;
  assign VBlank      = vblank_q;
  assign VSync       = vsync_q;
  assign ma          = ma_q;
  assign ra          = ra_q;
  assign char_fetch  = char_fetch_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_cbm2_video_timing.sv
// tb/tb_cbm2_video_timing.sv - self-checking bench for cbm2_video_timing
`timescale 1ns/1ps
module tb_cbm2_video_timing;

  localparam int CLK_DIV    = 4;
  localparam int H_ACTIVE   = 32;
  localparam int H_SS       = 36;
  localparam int H_SE       = 40;
  localparam int H_TOTAL    = 48;
  localparam int V_ACTIVE   = 24;
  localparam int COLS       = 4;
  localparam int NTSC_TOTAL = 30;
  localparam int NTSC_VSS   = 26;
  localparam int NTSC_VSE   = 29;
  localparam int PAL_TOTAL  = 36;
  localparam int PAL_VSS    = 30;
  localparam int PAL_VSE    = 33;
  localparam int FETCHES    = V_ACTIVE * COLS;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        pal = 1'b0;
  logic        ce_pix;
  logic [9:0]  hcount;
  logic [8:0]  vcount;
  logic        HBlank, HSync, VBlank, VSync;
  logic [10:0] ma;
  logic [2:0]  ra;
  logic        char_fetch, frame_start;

  always #5 clk = ~clk;

  cbm2_video_timing #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_SS(H_SS), .H_SE(H_SE), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .COLS(COLS),
    .NTSC_TOTAL(NTSC_TOTAL), .NTSC_VSS(NTSC_VSS), .NTSC_VSE(NTSC_VSE),
    .PAL_TOTAL(PAL_TOTAL), .PAL_VSS(PAL_VSS), .PAL_VSE(PAL_VSE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pal(pal), .ce_pix(ce_pix),
    .hcount(hcount), .vcount(vcount), .HBlank(HBlank), .HSync(HSync),
    .VBlank(VBlank), .VSync(VSync), .ma(ma), .ra(ra),
    .char_fetch(char_fetch), .frame_start(frame_start)
  );

  logic [39:0] act_vec;
  assign act_vec = {ce_pix, hcount, vcount, HBlank, HSync, VBlank, VSync, ma, ra, char_fetch, frame_start};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: pixel index within the frame, geometry from plain arithmetic.
  logic pal_s = 1'b0, rst_s = 1'b0;
  always @(posedge clk) begin
    pal_s <= pal;
    rst_s <= reset_n;
  end

  int          m_cnt, m_pix, m_h, m_v, m_vt;
  bit          m_pal;
  logic        e_ce, e_hb, e_hs, e_vb, e_vs, e_cf, e_fs;
  logic [9:0]  e_h;
  logic [8:0]  e_v;
  logic [10:0] e_ma;
  logic [2:0]  e_ra;
  logic [39:0] exp_vec, first_act, first_exp;
  time         first_t;
  int          mon_err = 0;
  int          cf_cnt = 0, frame_cf_last = 0, frames_done = 0, bad_frames = 0;
  bit          cnt_valid = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n || !rst_s) begin
        m_cnt = 0; m_pix = -1; m_pal = 0;
        {e_ce, e_hb, e_hs, e_vb, e_vs, e_cf, e_fs} = '0;
        e_h = '0; e_v = '0; e_ma = '0; e_ra = '0;
        cf_cnt = 0; cnt_valid = 0;
      end else begin
        m_cnt++;
        e_ce = 0; e_cf = 0; e_fs = 0;
        if (m_cnt % CLK_DIV == 0) begin
          e_ce = 1;
          m_vt = m_pal ? PAL_TOTAL : NTSC_TOTAL;
          if (m_pix < 0 || m_pix == H_TOTAL * m_vt - 1) begin
            m_pix = 0; m_pal = pal_s; e_fs = 1;
          end else begin
            m_pix++;
          end
          m_h = m_pix % H_TOTAL;
          m_v = m_pix / H_TOTAL;
          e_h = 10'(m_h);
          e_v = 9'(m_v);
          e_hb = (m_h >= H_ACTIVE);
          e_hs = (m_h >= H_SS) && (m_h < H_SE);
          e_vb = (m_v >= V_ACTIVE);
          e_vs = m_pal ? ((m_v >= PAL_VSS) && (m_v < PAL_VSE)) : ((m_v >= NTSC_VSS) && (m_v < NTSC_VSE));
          if (m_h < H_ACTIVE && m_v < V_ACTIVE) begin
            e_ma = 11'((m_v / 8) * COLS + m_h / 8);
            e_ra = 3'(m_v % 8);
            e_cf = (m_h % 8 == 0);
          end
        end
        if (e_fs) begin
          if (cnt_valid) begin
            frames_done++;
            frame_cf_last = cf_cnt;
            if (cf_cnt != FETCHES) bad_frames++;
          end
          cf_cnt = 0;
          cnt_valid = 1;
        end
        if (char_fetch) cf_cnt++;
      end
      exp_vec = {e_ce, e_h, e_v, e_hb, e_hs, e_vb, e_vs, e_ma, e_ra, e_cf, e_fs};
      if (act_vec !== exp_vec) begin
        if (mon_err == 0) begin first_act = act_vec; first_exp = exp_vec; first_t = $time; end
        mon_err++;
      end
    end
  end

  typedef struct {
    int h; int v; logic pal_in;
    logic hb; logic hs; logic vb; logic vs;
    logic [10:0] ma; logic [2:0] ra; logic cf;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int h, input int v, input logic p, input logic hb, input logic hs,
                     input logic vb, input logic vs, input int m, input int r, input logic cf);
    vec_t e;
    e.h = h; e.v = v; e.pal_in = p; e.hb = hb; e.hs = hs; e.vb = vb; e.vs = vs;
    e.ma = 11'(m); e.ra = 3'(r); e.cf = cf;
    tbl.push_back(e);
  endtask

  task automatic first_pixel(input string tag);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!ce_pix && n < 20);
    check({tag, " ce latency"}, 64'(n), 64'(CLK_DIV));
    check({tag, " first pixel"}, 64'({hcount, vcount, frame_start, HBlank, VBlank, ma, ra, char_fetch}),
          64'({10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 11'd0, 3'd0, 1'b1}));
  endtask

  task automatic measure_frame(output int n, output int vs_clk, output int hs_clk);
    n = 0; vs_clk = 0; hs_clk = 0;
    do begin
      @(posedge clk); #1; n++;
      if (VSync) vs_clk++;
      if (HSync) hs_clk++;
    end while (!frame_start && n < 20000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cur, p, vs_clk, hs_clk, rst_at;

    add( 7, 0, 0, 0,0,0,0,  0,0,0);
    add( 8, 0, 0, 0,0,0,0,  1,0,1);
    add(31, 0, 0, 0,0,0,0,  3,0,0);
    add(32, 0, 0, 1,0,0,0,  3,0,0);
    add(35, 0, 0, 1,0,0,0,  3,0,0);
    add(36, 0, 0, 1,1,0,0,  3,0,0);
    add(39, 0, 0, 1,1,0,0,  3,0,0);
    add(40, 0, 0, 1,0,0,0,  3,0,0);
    add(47, 0, 0, 1,0,0,0,  3,0,0);
    add( 0, 1, 0, 0,0,0,0,  0,1,1);
    add( 0, 7, 0, 0,0,0,0,  0,7,1);
    add(24, 7, 0, 0,0,0,0,  3,7,1);
    add( 0, 8, 1, 0,0,0,0,  4,0,1);
    add(24,23, 1, 0,0,0,0, 11,7,1);
    add(31,23, 1, 0,0,0,0, 11,7,0);
    add( 0,24, 1, 0,0,1,0, 11,7,0);
    add( 0,25, 1, 0,0,1,0, 11,7,0);
    add( 0,26, 1, 0,0,1,1, 11,7,0);
    add(47,27, 1, 1,0,1,1, 11,7,0);
    add( 0,28, 1, 0,0,1,1, 11,7,0);
    add( 0,29, 1, 0,0,1,0, 11,7,0);
    add(47,29, 1, 1,0,1,0, 11,7,0);

    #1 reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset outputs", 64'(act_vec), 64'd0);

    reset_n = 1'b1;
    first_pixel("release");
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ce_pix && n < 20);
    check("ce period", 64'(n), 64'(CLK_DIV));
    cur = 1;

    // Walk the NTSC frame through its boundary pixels; pal rises mid-frame.
    foreach (tbl[i]) begin
      p = tbl[i].v * H_TOTAL + tbl[i].h;
      repeat ((p - cur) * CLK_DIV) @(posedge clk);
      #1;
      cur = p;
      check($sformatf("vec h%0d v%0d", tbl[i].h, tbl[i].v),
            64'({ce_pix, hcount, vcount, HBlank, HSync, VBlank, VSync, ma, ra, char_fetch}),
            64'({1'b1, 10'(tbl[i].h), 9'(tbl[i].v), tbl[i].hb, tbl[i].hs, tbl[i].vb, tbl[i].vs,
                 tbl[i].ma, tbl[i].ra, tbl[i].cf}));
      pal = tbl[i].pal_in;
    end

    repeat (CLK_DIV) @(posedge clk);
    #1;
    check("ntsc frame wrap", 64'({frame_start, hcount, vcount}), 64'({1'b1, 19'd0}));
    @(negedge clk); #1;
    check("ntsc fetch count", 64'(frame_cf_last), 64'(FETCHES));

    measure_frame(n, vs_clk, hs_clk);
    check("pal frame period", 64'(n), 64'(H_TOTAL * PAL_TOTAL * CLK_DIV));
    check("pal vsync clks", 64'(vs_clk), 64'((PAL_VSE - PAL_VSS) * H_TOTAL * CLK_DIV));
    check("pal hsync clks", 64'(hs_clk), 64'((H_SE - H_SS) * PAL_TOTAL * CLK_DIV));
    @(negedge clk); #1;
    check("pal fetch count", 64'(frame_cf_last), 64'(FETCHES));

    // Mid-pixel asynchronous reset at h=20, v=10.
    repeat ((10 * H_TOTAL + 20) * CLK_DIV) @(posedge clk);
    #1;
    check("pre-reset position", 64'({hcount, vcount}), 64'({10'd20, 9'd10}));
    #2 reset_n = 1'b0;
    #1;
    check("async reset outputs", 64'(act_vec), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    pal = 1'b0;
    first_pixel("re-release");
    measure_frame(n, vs_clk, hs_clk);
    check("ntsc frame period", 64'(n), 64'(H_TOTAL * NTSC_TOTAL * CLK_DIV));
    check("ntsc vsync clks", 64'(vs_clk), 64'((NTSC_VSE - NTSC_VSS) * H_TOTAL * CLK_DIV));

    // Random mode toggles plus one short random reset, checked by the model.
    rst_at = $urandom_range(6000, 14000);
    for (int c = 0; c < 24000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 399) == 0) pal = ~pal;
      if (c == rst_at) begin
        reset_n = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
    end
    @(negedge clk); #1;

    check($sformatf("model compare (first at %0t got %h exp %h)", first_t, first_act, first_exp),
          64'(mon_err), 64'd0);
    check("frames with wrong fetch count", 64'(bad_frames), 64'd0);
    check("frames observed", 64'(frames_done >= 5), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
